uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte-producing requesters, such as the instruction fetcher and the bitty core. It replaces the FSM-driven static tx mux with a registered round-robin arbiter and per-requester completion handshake. It sits between the requesters and uart_module's tx_en/data_tx/tx_done interface. Only one byte is in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters (2..4); index 0 gets first grant after reset
TIMEOUT_CYCLES, 65535, WAIT_DONE cycles before forced release (ARB_TIMEOUT_EN only); fits 16-bit counter; must exceed 10*clks_per_bit max (52080)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset low on a clk edge resets the block)
req_valid  in  NUM_REQ  per-requester "byte pending"; held high until req_done
req_data  in  8*NUM_REQ  flattened bytes; requester i at [8*i+7:8*i]
req_done  out  NUM_REQ  one-cycle pulse to granted requester when its byte has been sent
grant  out  NUM_REQ  one-hot owner of the transmitter; 0 when idle
tx_en  out  1  one-cycle start pulse to uart_module
tx_data  out  8  registered byte to uart_module data_tx
tx_done  in  1  uart_module transmit-complete pulse
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky timeout flag; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset values: state=IDLE, grant=0, tx_en=0, tx_data=8'h00, req_done=0, busy=0, timeout_err=0, rr pointer=0 (requester 0 searched first).
- Reset is sampled on every edge. Reset mid-transfer abandons the byte: no req_done is pulsed, and tx_en is not re-issued.
- State IDLE: when any req_valid bit is high, select the first set bit searching circularly from the pointer. Register grant (one-hot) and tx_data=req_data[sel]. Go to START. With no request, remain in IDLE.
- State START: tx_en=1 for exactly this cycle. Go to WAIT_DONE.
- State WAIT_DONE: hold grant and tx_data. When tx_done=1, pulse req_done[sel]=1 on the next cycle, set pointer=(sel+1) mod NUM_REQ, clear grant, and go to IDLE.
- tx_done seen in IDLE or START is ignored.
- Latency: req_valid high at edge n gives grant/tx_data valid and tx_en high in cycle n+1. tx_done at edge m gives req_done high in cycle m+1 and grant=0 in cycle m+1. The earliest next tx_en is cycle m+2.
- req_done and the next arbitration decision are not in the same cycle. A requester dropping req_valid in the req_done cycle is never re-granted for the same byte.
- Early deassert of req_valid after grant: the latched byte is still sent and req_done is still pulsed.
- req_data changes after grant: no effect, because data is latched.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- Simultaneous new request and tx_done: the new request is arbitrated in IDLE one cycle later.
- busy = (state != IDLE).

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a 16-bit counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle without tx_done. When it reaches TIMEOUT_CYCLES, the arbiter returns to IDLE, clears grant, advances the pointer, and sets timeout_err=1 (sticky until reset). req_done is not pulsed, so the requester keeps req_valid high and is retried after the others.
- Undefined: no counter is built, WAIT_DONE is left only on tx_done, and timeout_err is tied to 0.

Decomposition:
- Shared package bitty_uart_pkg contains:
  - state encodings: IDLE=2'd0, START=2'd1, WAIT_DONE=2'd2
  - byte width 8
  - default TIMEOUT_CYCLES
  - baud clks_per_bit constants 5208/2604/868/434
- One combinational sub-module, rr_pick: inputs req_valid and pointer; outputs one-hot selection, index, and any_valid.

Test Plan:
- Single requester: req_valid=2'b01, req_data[7:0]=8'hA5 → cycle+1: grant=01, tx_en=1 (one cycle), tx_data=A5. tx_done pulsed 20 cycles later → req_done=01 next cycle, grant=00, busy=0.
- Contention: both valid continuously, bytes 8'h11 (req0) and 8'h22 (req1), four transfers → tx_data order 11,22,11,22. Each req_done goes to the matching requester.
- Pointer carryover: req1 alone sends 8'h33, then both valid → req0 is granted first (pointer=0 after req1). Repeat with req0 alone first → req1 is granted first.
- Reset mid-transfer: reset=0 for one edge during WAIT_DONE → all outputs at reset values next cycle, no req_done. A later tx_done is ignored in IDLE.
- Spurious/early events: tx_done pulsed in IDLE → no req_done. req_valid dropped after grant, req_data changed to 8'hFF → original byte kept, req_done still pulsed.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, tx_done never sent → release after 100 WAIT_DONE cycles, timeout_err=1 sticky, no req_done, other valid requester granted next.

Source files
------------

// File: rtl/bitty_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitty_uart_pkg
// Brief    : Shared types and constants for the bitty UART transmit path:
//            arbiter state encoding, byte width, default timeout and the
//            clks_per_bit values for the supported baud rates.
// Revision : 1.0 - initial release
// ============================================================================
package bitty_uart_pkg;

   // Transmit arbiter states
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

   localparam int BYTE_W = 8;

   // Longest frame is 10 bits at 5208 clks/bit (52080 cycles); stay above it
   localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

   // clks_per_bit for a 50 MHz clock
   localparam int CLKS_PER_BIT_9600   = 5208;
   localparam int CLKS_PER_BIT_19200  = 2604;
   localparam int CLKS_PER_BIT_57600  = 868;
   localparam int CLKS_PER_BIT_115200 = 434;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector. Returns the first set
//            req_valid bit found by searching circularly from pointer, as a
//            one-hot vector and as an index, plus an any-valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
   import bitty_uart_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   sel_index,
   output logic               any_valid
);

   // Circular first-set search starting at pointer
   always_comb begin
      onehot    = '0;
      sel_index = '0;
      any_valid = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any_valid && req_valid[(int'(pointer) + k) % NUM_REQ]) begin
            any_valid = 1'b1;
            onehot[(int'(pointer) + k) % NUM_REQ] = 1'b1;
            sel_index = IDX_W'((int'(pointer) + k) % NUM_REQ);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one UART transmitter between
//            NUM_REQ byte producers. One byte in flight at a time; the
//            granted requester receives a one-cycle req_done pulse once
//            uart_module reports tx_done.
// Options  : ARB_TIMEOUT_EN - when defined, a WAIT_DONE watchdog releases
//            the transmitter after TIMEOUT_CYCLES and sets a sticky
//            timeout_err; when undefined, timeout_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
   import bitty_uart_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      tx_en,
   output logic [BYTE_W-1:0]         tx_data,
   input  logic                      tx_done,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t         state, state_next;
   logic [NUM_REQ-1:0] grant_next, done_next;
   logic [BYTE_W-1:0]  data_next;
   logic [IDX_W-1:0]   pointer, pointer_next;
   logic [IDX_W-1:0]   sel, sel_next;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_index;
   logic               pick_any;

   // Pointer moves to the requester after the one just served
   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
      if (cur == IDX_W'(NUM_REQ - 1)) begin
         return '0;
      end
      return cur + 1'b1;
   endfunction

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_valid (req_valid),
      .pointer   (pointer),
      .onehot    (pick_onehot),
      .sel_index (pick_index),
      .any_valid (pick_any)
   );

   // tx_en is exactly the single START cycle
   assign tx_en = (state == START);
   assign busy  = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wait_cnt, wait_cnt_next;
   logic        timeout_flag, timeout_flag_next;

   assign timeout_err = timeout_flag;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
   assign timeout_err        = 1'b0;
`endif

   // Next-state and next-output decode
   always_comb begin
      state_next   = state;
      grant_next   = grant;
      data_next    = tx_data;
      done_next    = '0;
      pointer_next = pointer;
      sel_next     = sel;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_next     = wait_cnt;
      timeout_flag_next = timeout_flag;
`endif
      case (state)
         IDLE: begin
            if (pick_any) begin
               grant_next = pick_onehot;
               sel_next   = pick_index;
               data_next  = req_data[BYTE_W*pick_index +: BYTE_W];
               state_next = START;
            end
         end
         START: begin
            state_next = WAIT_DONE;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_next = '0;
`endif
         end
         WAIT_DONE: begin
            if (tx_done) begin
               done_next    = grant;
               grant_next   = '0;
               pointer_next = next_ptr(sel);
               state_next   = IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (wait_cnt == TIMEOUT_LAST) begin
               // Forced release: no req_done, requester is retried later
               grant_next        = '0;
               pointer_next      = next_ptr(sel);
               timeout_flag_next = 1'b1;
               state_next        = IDLE;
            end else begin
               wait_cnt_next = wait_cnt + 16'd1;
            end
`endif
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   // State and registered outputs; active-low synchronous reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         grant    <= '0;
         tx_data  <= '0;
         req_done <= '0;
         pointer  <= '0;
         sel      <= '0;
`ifdef ARB_TIMEOUT_EN
         wait_cnt     <= '0;
         timeout_flag <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         grant    <= grant_next;
         tx_data  <= data_next;
         req_done <= done_next;
         pointer  <= pointer_next;
         sel      <= sel_next;
`ifdef ARB_TIMEOUT_EN
         wait_cnt     <= wait_cnt_next;
         timeout_flag <= timeout_flag_next;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter with three requesters.
//            Directed transfers followed by randomized traffic compared
//            against a transaction-level round-robin model.
// Options  : ARB_TIMEOUT_EN - adds the watchdog release scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int N = 3;
`ifdef ARB_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 65535;
`endif

   logic           clk;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_done;
   logic [N-1:0]   grant;
   logic           tx_en;
   logic [7:0]     tx_data;
   logic           tx_done;
   logic           busy;
   logic           timeout_err;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] pend [N];
   int         mptr;

   uart_tx_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_done    (req_done),
      .grant       (grant),
      .tx_en       (tx_en),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something never returns
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample 1 ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      tx_done   = 1'b0;
      step();
      check("rst_grant", grant, 0);
      check("rst_tx_en", tx_en, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_req_done", req_done, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout_err", timeout_err, 0);
      reset = 1'b1;
      mptr  = 0;
   endtask

   task automatic set_req(input int i, input logic [7:0] b);
      pend[i]            = b;
      req_data[8*i +: 8] = b;
      req_valid[i]       = 1'b1;
   endtask

   // One full transfer starting from an IDLE cycle; ends in the req_done cycle
   task automatic send(input int idx, input logic [7:0] b, input int dly,
                       input bit drop, input bit mangle);
      logic [N-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      step();
      check("grant", grant, oh);
      check("tx_en_start", tx_en, 1);
      check("tx_data", tx_data, b);
      check("busy_start", busy, 1);
      check("no_done_start", req_done, 0);
      if (drop) req_valid[idx] = 1'b0;
      if (mangle) req_data[8*idx +: 8] = ~b;
      for (int k = 0; k < dly; k++) begin
         step();
         check("tx_en_single", tx_en, 0);
         check("grant_hold", grant, oh);
         check("tx_data_hold", tx_data, b);
         check("no_early_done", req_done, 0);
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("req_done", req_done, oh);
      check("grant_release", grant, 0);
      check("busy_release", busy, 0);
      check("tx_en_release", tx_en, 0);
      mptr = (idx + 1) % N;
   endtask

   initial begin
      int exp;
      int cnt;
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      tx_done   = 1'b0;
      do_reset();

      // Single requester, tx_done 20 cycles after the start pulse
      set_req(0, 8'hA5);
      send(0, 8'hA5, 19, 0, 0);
      req_valid = '0;
      step();
      check("single_done_once", req_done, 0);
      check("single_idle", busy, 0);

      // Contention between requesters 0 and 1, both held valid
      do_reset();
      set_req(0, 8'h11);
      set_req(1, 8'h22);
      send(0, 8'h11, 3, 0, 0);
      send(1, 8'h22, 3, 0, 0);
      send(0, 8'h11, 3, 0, 0);
      send(1, 8'h22, 3, 0, 0);
      req_valid = '0;

      // Pointer carryover: req1 alone, then both -> req0 first
      do_reset();
      set_req(1, 8'h33);
      send(1, 8'h33, 2, 0, 0);
      req_valid[1] = 1'b0;
      set_req(0, 8'h40);
      set_req(1, 8'h41);
      send(0, 8'h40, 2, 0, 0);
      req_valid[0] = 1'b0;
      send(1, 8'h41, 2, 0, 0);
      req_valid = '0;
      // req0 alone, then both -> req1 first
      set_req(0, 8'h44);
      send(0, 8'h44, 2, 0, 0);
      req_valid[0] = 1'b0;
      set_req(0, 8'h45);
      set_req(1, 8'h46);
      send(1, 8'h46, 2, 0, 0);
      req_valid[1] = 1'b0;
      send(0, 8'h45, 2, 0, 0);
      req_valid = '0;

      // Reset during WAIT_DONE abandons the byte
      set_req(1, 8'h5A);
      step();
      check("mid_grant", grant, 3'b010);
      step();
      step();
      do_reset();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("post_rst_no_done", req_done, 0);
      check("post_rst_idle", busy, 0);
      check("post_rst_grant", grant, 0);
      set_req(0, 8'h61);
      set_req(1, 8'h62);
      send(0, 8'h61, 2, 0, 0);
      req_valid = '0;

      // Spurious tx_done in IDLE, then early deassert plus data change
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      check("spurious_no_done", req_done, 0);
      check("spurious_idle", busy, 0);
      set_req(2, 8'h7C);
      send(2, 8'h7C, 5, 1, 1);
      req_valid = '0;

      // Randomized traffic against the round-robin model
      do_reset();
      for (int t = 0; t < 80; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               set_req(i, 8'($urandom));
            end
         end
         exp = -1;
         for (int k = 0; k < N; k++) begin
            if (exp < 0 && req_valid[(mptr + k) % N]) exp = (mptr + k) % N;
         end
         if (exp < 0) begin
            tx_done = 1'($urandom_range(0, 1));
            step();
            tx_done = 1'b0;
            check("rand_idle_grant", grant, 0);
            check("rand_idle_done", req_done, 0);
            check("rand_idle_busy", busy, 0);
         end else begin
            send(exp, pend[exp], int'($urandom_range(1, 8)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            req_valid[exp] = 1'b0;
         end
      end
      req_valid = '0;
      step();

`ifdef ARB_TIMEOUT_EN
      // Watchdog release: no tx_done ever arrives for requester 0
      do_reset();
      set_req(0, 8'h66);
      set_req(1, 8'h77);
      step();
      check("tmo_grant", grant, 3'b001);
      cnt = 0;
      while (grant != 0 && cnt < 200) begin
         step();
         cnt++;
         if (req_done != 0) check("tmo_no_done", req_done, 0);
      end
      check("tmo_release_cycles", cnt, 101);
      check("tmo_err_set", timeout_err, 1);
      check("tmo_idle", busy, 0);
      send(1, 8'h77, 2, 0, 0);
      req_valid[1] = 1'b0;
      send(0, 8'h66, 2, 0, 0);
      req_valid = '0;
      check("tmo_err_sticky", timeout_err, 1);
      do_reset();
`else
      cnt = 0;
      check("no_timeout_err", timeout_err, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
